// File: rtl/multicycle_issue_unit_pkg.sv
// Shared CPU definitions for the multi-cycle ARITHM path.
//   - 4-bit multi-cycle opcodes, shared with the multi-cycle ALU.
//   - Issue FSM state encoding.
package multicycle_issue_unit_pkg;

    localparam int unsigned MC_OP_W = 4;

    localparam logic [MC_OP_W-1:0] OP_MULTS  = 4'h0;
    localparam logic [MC_OP_W-1:0] OP_MULTU  = 4'h1;
    localparam logic [MC_OP_W-1:0] OP_MULTFP = 4'h2;
    localparam logic [MC_OP_W-1:0] OP_DIVS   = 4'h3;
    localparam logic [MC_OP_W-1:0] OP_DIVU   = 4'h4;
    localparam logic [MC_OP_W-1:0] OP_MODS   = 4'h5;
    localparam logic [MC_OP_W-1:0] OP_MODU   = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mc_state_e;

endpackage

// File: rtl/multicycle_issue_unit_cache.sv
// mc_result_cache: one-entry result cache for the multi-cycle issue unit.
// Only built when MC_RESULT_CACHE_EN is defined.
// Ports:
//   clk, reset (async, active-low)
//   wr_en, wr_opcode, wr_a, wr_b, wr_y : fill port, overwrites the entry
//   rd_opcode, rd_a, rd_b              : lookup tag
//   hit, hit_y                         : combinational tag match and cached result
`ifdef MC_RESULT_CACHE_EN
module mc_result_cache
    import multicycle_issue_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [MC_OP_W-1:0] wr_opcode,
    input  logic [31:0]        wr_a,
    input  logic [31:0]        wr_b,
    input  logic [31:0]        wr_y,
    input  logic [MC_OP_W-1:0] rd_opcode,
    input  logic [31:0]        rd_a,
    input  logic [31:0]        rd_b,
    output logic               hit,
    output logic [31:0]        hit_y
);

    logic               valid_q, valid_d;
    logic [MC_OP_W-1:0] opcode_q, opcode_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        y_q, y_d;

    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        if (wr_en) begin
            valid_d  = 1'b1;
            opcode_d = wr_opcode;
            a_d      = wr_a;
            b_d      = wr_b;
            y_d      = wr_y;
        end
    end

    // valid is only ever cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
        end
    end

    assign hit   = valid_q && (opcode_q == rd_opcode) && (a_q == rd_a) && (b_q == rd_b);
    assign hit_y = y_q;

endmodule
`endif

// File: rtl/multicycle_issue_unit.sv
// multicycle_issue_unit: EX-stage front end for the multi-cycle ARITHM ALU.
// Launches mul/div/mod ops with a one-cycle start pulse, stalls the pipeline
// until the ALU finishes, and presents the result for writeback. Flushes
// during an in-flight op are absorbed so a squashed op never writes back.
// Optional one-entry result cache: define MC_RESULT_CACHE_EN.
// Ports:
//   clk, reset (async, active-low)
//   ex_valid, ex_mc, ex_opcode, ex_a, ex_b, ex_dreg : EX-stage instruction
//   flush        : squash EX instruction and any in-flight op
//   stall        : combinational pipeline hold
//   alu_start, alu_opcode, alu_a, alu_b : registered ALU launch
//   alu_done, alu_y                     : ALU completion
//   result_valid, result, result_dreg   : registered writeback strobe
//
// state | meaning
// IDLE  | waiting for a multi-cycle request
// BUSY  | ALU running an op that will write back
// DRAIN | ALU running a flushed op; its result is dropped
// DONE  | result presented for one cycle
module multicycle_issue_unit
    import multicycle_issue_unit_pkg::*;
#(
    parameter int unsigned DREG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic               ex_mc,
    input  logic [MC_OP_W-1:0] ex_opcode,
    input  logic [31:0]        ex_a,
    input  logic [31:0]        ex_b,
    input  logic [DREG_W-1:0]  ex_dreg,
    input  logic               flush,
    output logic               stall,
    output logic               alu_start,
    output logic [MC_OP_W-1:0] alu_opcode,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic               alu_done,
    input  logic [31:0]        alu_y,
    output logic               result_valid,
    output logic [31:0]        result,
    output logic [DREG_W-1:0]  result_dreg
);

    mc_state_e          state_q, state_d;
    logic [MC_OP_W-1:0] opcode_q, opcode_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [DREG_W-1:0]  dreg_q, dreg_d;
    logic               alu_start_q, alu_start_d;
    logic               result_valid_q, result_valid_d;
    logic [31:0]        result_q, result_d;
    logic [DREG_W-1:0]  result_dreg_q, result_dreg_d;

    logic               req;
    logic               cache_hit;
    logic [31:0]        cache_y;

    assign req = ex_valid & ex_mc & ~flush;

`ifdef MC_RESULT_CACHE_EN
    logic cache_wr;

    // only results that actually write back are cached
    assign cache_wr = (state_q == ST_BUSY) && alu_done && !flush;

    mc_result_cache u_cache (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (cache_wr),
        .wr_opcode (opcode_q),
        .wr_a      (a_q),
        .wr_b      (b_q),
        .wr_y      (alu_y),
        .rd_opcode (ex_opcode),
        .rd_a      (ex_a),
        .rd_b      (ex_b),
        .hit       (cache_hit),
        .hit_y     (cache_y)
    );
`else
    assign cache_hit = 1'b0;
    assign cache_y   = '0;
`endif

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        a_d            = a_q;
        b_d            = b_q;
        dreg_d         = dreg_q;
        alu_start_d    = 1'b0;
        result_valid_d = 1'b0;
        result_d       = result_q;
        result_dreg_d  = result_dreg_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (cache_hit) begin
                        result_d       = cache_y;
                        result_dreg_d  = ex_dreg;
                        result_valid_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        opcode_d    = ex_opcode;
                        a_d         = ex_a;
                        b_d         = ex_b;
                        dreg_d      = ex_dreg;
                        alu_start_d = 1'b1;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (alu_done && !flush) begin
                    result_d       = alu_y;
                    result_dreg_d  = dreg_q;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end else if (alu_done) begin
                    // flush landed on the completion cycle: nothing left to drain
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (alu_done) state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            opcode_q       <= '0;
            a_q            <= '0;
            b_q            <= '0;
            dreg_q         <= '0;
            alu_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_dreg_q  <= '0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            a_q            <= a_d;
            b_q            <= b_d;
            dreg_q         <= dreg_d;
            alu_start_q    <= alu_start_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_dreg_q  <= result_dreg_d;
        end
    end

    // DONE releases the pipeline, so the same instruction is not reissued
    assign stall        = req & (state_q != ST_DONE);
    assign alu_start    = alu_start_q;
    assign alu_opcode   = opcode_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_dreg  = result_dreg_q;

endmodule
